// File: rtl/cmp_sd_decimator_if.sv
// Sample handshake bundle between the comparator decimator and its consumer.
interface cmp_sd_decimator_if #(
    parameter int WIN_LOG2 = 8
);
    logic [WIN_LOG2-1:0] sample;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/cmp_sd_decimator.sv
// Comparator back-end: synchronise and deglitch the raw comparator bit for the
// sigma-delta feedback, then count ones per window into a handshaked sample.
module cmp_sd_decimator #(
    parameter int WIN_LOG2   = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      cmp_in,
    output logic                      dac_fb,
    output logic                      overrun,
    output logic                      busy,
    cmp_sd_decimator_if.master        smp
);
    localparam int ACC_W = WIN_LOG2 + 1;
    localparam logic [WIN_LOG2-1:0] SAMPLE_MAX  = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] WCNT_LAST   = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] WCNT_ONE    = {{(WIN_LOG2-1){1'b0}}, 1'b1};
    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2
    } state_t;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // The accumulator can only exceed the sample range by reaching exactly 2^WIN_LOG2.
    function automatic logic [WIN_LOG2-1:0] saturate(input logic [ACC_W-1:0] a);
        return a[WIN_LOG2] ? SAMPLE_MAX : a[WIN_LOG2-1:0];
    endfunction

    logic                s1_q, s1_d, s2_q, s2_d;
    logic [2:0]          hist_q, hist_d;
    logic                dac_fb_q, dac_fb_d;
    state_t              state_q, state_d;
    logic [3:0]          scnt_q, scnt_d;
    logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                close_q, close_d;
    logic [WIN_LOG2-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                busy_q, busy_d;

    // Two-flop synchroniser, 3-deep history and majority vote.
    always_comb begin
        s1_d     = cmp_in;
        s2_d     = s1_q;
        hist_d   = {hist_q[1:0], s2_q};
        dac_fb_d = majority3(hist_q);
    end

    // Conversion sequencer; close_q flags that acc_q holds a finished window.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        wcnt_d  = {WIN_LOG2{1'b0}};
        acc_d   = {ACC_W{1'b0}};
        close_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                scnt_d = 4'd0;
                if (en) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    scnt_d  = 4'd0;
                end else if (scnt_q == SETTLE_LAST) begin
                    state_d = ST_ACCUM;
                    scnt_d  = 4'd0;
                end else begin
                    scnt_d  = scnt_q + 4'd1;
                end
            end
            ST_ACCUM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = (close_q ? {ACC_W{1'b0}} : acc_q) + {{WIN_LOG2{1'b0}}, dac_fb_q};
                    wcnt_d  = wcnt_q + WCNT_ONE;
                    close_d = (wcnt_q == WCNT_LAST);
                end
            end
            default: begin
                state_d = ST_IDLE;
                scnt_d  = 4'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Output sample register and valid/ready handshake with sticky overrun.
    always_comb begin
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (close_q) begin
            sample_d = saturate(acc_q);
            valid_d  = 1'b1;
            if (valid_q && !smp.sample_ready) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (valid_q && smp.sample_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            hist_q    <= 3'd0;
            dac_fb_q  <= 1'b0;
            state_q   <= ST_IDLE;
            scnt_q    <= 4'd0;
            wcnt_q    <= {WIN_LOG2{1'b0}};
            acc_q     <= {ACC_W{1'b0}};
            close_q   <= 1'b0;
            sample_q  <= {WIN_LOG2{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            hist_q    <= hist_d;
            dac_fb_q  <= dac_fb_d;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            wcnt_q    <= wcnt_d;
            acc_q     <= acc_d;
            close_q   <= close_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign dac_fb           = dac_fb_q;
    assign overrun          = overrun_q;
    assign busy             = busy_q;
    assign smp.sample       = sample_q;
    assign smp.sample_valid = valid_q;
endmodule

// File: tb/tb_cmp_sd_decimator.sv
// Directed scenarios with randomized comparator/ready stimulus, checked every
// cycle against an edge-indexed reference of the comparator stream.
module tb_cmp_sd_decimator;
    localparam int WL   = 8;
    localparam int SC   = 4;
    localparam int WIN  = 256;
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic rst, en, cmp_in;
    logic dac_fb, overrun, busy;

    cmp_sd_decimator_if #(.WIN_LOG2(WL)) sif ();

    cmp_sd_decimator #(.WIN_LOG2(WL), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in),
        .dac_fb(dac_fb), .overrun(overrun), .busy(busy), .smp(sif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference: eff[e] is the comparator value captured at edge e (0 if lost to reset).
    bit eff [MAXE];
    int edge_n = -1;
    bit run_m, close_m, v_m, ov_m, dac_m;
    int start_m, sum_m, close_val_m, s_m;

    int mode, cyc, density;
    bit rand_ready;
    int r_edge, at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    function automatic bit eget(input int i);
        return (i < 0) ? 1'b0 : eff[i];
    endfunction

    function automatic logic gen(input int m, input int c);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (c % 4) < 2;
            3:       return (c % 8) == 0;
            4:       return (c % 8) != 0;
            default: return $urandom_range(0, 99) < density;
        endcase
    endfunction

    task automatic model_edge();
        int k;
        edge_n++;
        if (edge_n >= MAXE) begin
            $display("FAIL edge_budget exceeded at edge %0d", edge_n);
            $fatal(1);
        end
        eff[edge_n] = rst ? 1'b0 : cmp_in;
        if (rst) begin
            for (int i = 0; i < 6; i++) if (edge_n - i >= 0) eff[edge_n - i] = 1'b0;
            run_m = 0; close_m = 0; v_m = 0; ov_m = 0; s_m = 0; sum_m = 0; dac_m = 0;
            return;
        end
        if (close_m) begin
            if (v_m && !sif.sample_ready) ov_m = 1;
            s_m = close_val_m;
            v_m = 1;
            close_m = 0;
        end else if (v_m && sif.sample_ready) begin
            v_m = 0;
        end
        if (!run_m) begin
            if (en) begin run_m = 1; start_m = edge_n; sum_m = 0; end
        end else if (!en) begin
            run_m = 0;
        end else begin
            k = edge_n - start_m - (SC + 1);
            if (k >= 0) begin
                sum_m += dac_m;
                if (k % WIN == WIN - 1) begin
                    close_m = 1;
                    close_val_m = (sum_m > WIN - 1) ? WIN - 1 : sum_m;
                    sum_m = 0;
                end
            end
        end
        dac_m = (eget(edge_n-3) + eget(edge_n-4) + eget(edge_n-5)) >= 2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("dac_fb", dac_fb, dac_m);
        chk("busy", busy, run_m);
        chk("sample_valid", sif.sample_valid, v_m);
        chk("overrun", overrun, ov_m);
        if (v_m) chk("sample", sif.sample, s_m);
        cyc++;
        if (mode == 5 && cyc % 64 == 0) density = $urandom_range(0, 100);
        cmp_in = gen(mode, cyc);
        if (rand_ready) sif.sample_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic wait_valid(output int rise);
        rise = -1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (sif.sample_valid === 1'b1) begin
                rise = edge_n;
                break;
            end
        end
        if (rise < 0) chk("valid_timeout", sif.sample_valid, 1);
    endtask

    task automatic start_scenario(input int m, input bit rdy);
        mode = m; cyc = 0; rand_ready = 0;
        cmp_in = gen(m, 0);
        sif.sample_ready = rdy;
        en = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        r_edge = edge_n;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cmp_in = 1'b1; sif.sample_ready = 1'b1;
        mode = 1; cyc = 0; density = 50; rand_ready = 0;

        // Reset with input high and enable asserted, then full scale.
        repeat (3) tick();
        chk("rst_dac", dac_fb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", sif.sample_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sample", sif.sample, 0);
        rst = 1'b0;
        tick();
        r_edge = edge_n;
        chk("rel_busy", busy, 1);
        repeat (4) tick();
        chk("rel_dac", dac_fb, 1);
        wait_valid(at);
        chk("full_latency", at - r_edge, SC + WIN + 1);
        chk("full_sample", sif.sample, 255);
        repeat (WIN) tick();
        chk("full_valid2", sif.sample_valid, 1);
        chk("full_sample2", sif.sample, 255);

        // 50% square: the second window is free of reset edge effects.
        start_scenario(2, 1'b1);
        wait_valid(at);
        repeat (WIN) tick();
        chk("square_valid", sif.sample_valid, 1);
        chk("square_sample", sif.sample, 128);

        // Single-cycle high glitches on a low input.
        start_scenario(3, 1'b1);
        wait_valid(at);
        chk("glitch_hi_sample", sif.sample, 0);
        repeat (WIN) tick();
        chk("glitch_hi_sample2", sif.sample, 0);

        // Single-cycle low glitches on a high input.
        start_scenario(4, 1'b1);
        wait_valid(at);
        chk("glitch_lo_sample", sif.sample, 255);
        repeat (WIN) tick();
        chk("glitch_lo_sample2", sif.sample, 255);

        // Backpressure across two window closes.
        start_scenario(1, 1'b0);
        wait_valid(at);
        chk("bp_overrun1", overrun, 0);
        repeat (WIN) tick();
        chk("bp_valid2", sif.sample_valid, 1);
        chk("bp_overrun2", overrun, 1);
        sif.sample_ready = 1'b1;
        tick();
        sif.sample_ready = 1'b0;
        chk("bp_valid_drop", sif.sample_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);

        // Abort mid-window on random input, then re-enable.
        density = 70;
        start_scenario(5, 1'b1);
        repeat (SC + 100) tick();
        en = 1'b0;
        repeat (10) tick();
        chk("abort_busy", busy, 0);
        chk("abort_valid", sif.sample_valid, 0);
        en = 1'b1;
        tick();
        r_edge = edge_n;
        wait_valid(at);
        chk("abort_latency", at - r_edge, SC + WIN + 1);

        // Long random run with random ready.
        start_scenario(5, 1'b1);
        rand_ready = 1;
        repeat (1100) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cmp_sd_decimator.md
Name: cmp_sd_decimator

Overview:
- Digital back-end for the gate-level comparator stage.
- Takes the comparator's raw 1-bit output as an asynchronous input. Synchronises it, rejects single-cycle glitches and returns the filtered bit as the 1-bit sigma-delta feedback.
- Counts ones over a fixed window to produce a decimated multi-bit sample.
- Hands each sample to the digital outputs through a valid/ready handshake.

Parameters:
- WIN_LOG2, 8, log2 of the decimation window in clk cycles (window = 2^WIN_LOG2). Sample width equals WIN_LOG2.
- SETTLE_CYC, 4, cycles discarded after enable to flush the sync/filter pipeline. Range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  conversion enable, synchronous
- cmp_in  input  1  raw comparator output, asynchronous to clk
- dac_fb  output  1  filtered comparator bit, registered; drives the feedback DAC pin
- sample  output  WIN_LOG2  decimated result, stable while sample_valid=1
- sample_valid  output  1  result available
- sample_ready  input  1  consumer accepts sample when valid&ready on an edge
- overrun  output  1  sticky; a completed window overwrote an unaccepted sample
- busy  output  1  high in SETTLE or ACCUM

Behaviour:
- Reset (rst=1 at an edge): sync flops, history, dac_fb, accumulator, window counter, sample, sample_valid, overrun all 0; state IDLE; busy=0. rst has priority over every other input.
- Front end, always running independent of en:
  - s1<=cmp_in, s2<=s1.
  - h[2:0]<={h[1:0],s2}.
  - dac_fb<=majority(h).
  - A level on cmp_in sampled at edge 0 appears on dac_fb after edge 4.
  - A high or low excursion captured by exactly one edge never reaches dac_fb.
- FSM:
  - IDLE: accumulator and window counter held at 0. en=1 -> SETTLE.
  - SETTLE: counts SETTLE_CYC cycles, nothing accumulated, then -> ACCUM.
  - ACCUM: each cycle acc+=dac_fb and wcnt+=1. When wcnt reaches 2^WIN_LOG2-1 (the last accumulating cycle), the window closes:
    - next edge: sample<=min(acc_final, 2^WIN_LOG2-1);
    - sample_valid<=1;
    - acc and wcnt cleared;
    - stay in ACCUM for back-to-back windows with no gap cycles.
  - en=0 in SETTLE or ACCUM: -> IDLE at that edge; partial window discarded, no sample produced; existing sample/sample_valid untouched.
- Arithmetic:
  - Accumulator is WIN_LOG2+1 bits.
  - Full count 2^WIN_LOG2 saturates to all-ones (e.g. 256 -> 255 for WIN_LOG2=8).
- Handshake:
  - sample_valid falls on the edge where sample_valid&sample_ready.
  - While sample_valid=1, sample does not change unless a new window closes.
  - If a window closes while sample_valid=1 and sample_ready=0: sample overwritten, sample_valid stays 1, overrun<=1.
  - If ready and window-close coincide on the same edge: old sample consumed, new one loaded, sample_valid stays 1, no overrun.
- overrun clears only on rst.
- First sample latency from en sampled high at edge 0: sample_valid rises at edge SETTLE_CYC+2^WIN_LOG2+1.

Test Plan (defaults):
- Reset: hold rst 3 cycles with cmp_in=1, en=1 -> all outputs 0, busy=0. After release, dac_fb=1 within 4 edges and busy=1.
- Full scale: cmp_in=1 constant, en=1, ready=1 -> first sample_valid at edge 261, sample=255 (saturated); subsequent samples every 256 cycles, each 255.
- 50% square, period 4 cycles (2 high/2 low), ready=1 -> sample=128 on every window; dac_fb is the same square delayed 4 cycles.
- Glitch rejection: cmp_in=0 with 1-cycle high pulses every 8 cycles -> dac_fb stays 0, sample=0. The inverse case (1 with 1-cycle lows) gives sample=255.
- Backpressure: ready=0 across two window closes with cmp_in=1 -> overrun=1 after second close, sample_valid stays 1. Asserting ready for one cycle clears sample_valid; overrun remains 1.
- Abort: drop en at wcnt=100, re-raise 10 cycles later -> no sample from aborted window; next sample_valid arrives 4+256+1 edges after re-enable.
